// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg: shared state encoding, default sizes and counter-width helper
package sub_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_BITS_PER_CYCLE = 1;
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit XOR+MUX full adder used in the serial subtractor chain
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic axc;
  assign axc = a ^ cin;
  assign cout = axc ? b : a;
  assign s = axc ^ b;
endmodule

// File: rtl/sub_int32_serial.sv
// sub_int32_serial: bit-serial A - B (A + ~B + 1), BITS_PER_CYCLE bits per clock
// Define SUB_INT32_SERIAL_FLAGS_EN to add the borrow and ovf outputs.
module sub_int32_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff
`ifdef SUB_INT32_SERIAL_FLAGS_EN
  ,
  output logic             borrow,
  output logic             ovf
`endif
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry, accept, last;
  logic [BITS_PER_CYCLE:0] c;
  logic [BITS_PER_CYCLE-1:0] s;
  assign c[0] = carry;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    full_adder_cell u_cell (.a(a_sh[i]), .b(b_sh[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  // the unused encoding behaves as IDLE
  assign in_ready = state != RUN && state != DONE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign last = state == RUN && cnt == CW'(N - 1);
  always_comb begin
    nxt = IDLE;
    if (state == RUN) nxt = last ? DONE : RUN;
    else if (state == DONE) nxt = out_ready ? IDLE : DONE;
    else nxt = accept ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      carry <= 1'b1;
      diff <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_sh <= a;
        b_sh <= ~b;
        carry <= 1'b1;
        cnt <= '0;
        diff <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> BITS_PER_CYCLE;
        b_sh <= b_sh >> BITS_PER_CYCLE;
        carry <= c[BITS_PER_CYCLE];
        cnt <= cnt + 1'b1;
        diff <= {s, diff[WIDTH-1:BITS_PER_CYCLE]};
      end
    end
  end
`ifdef SUB_INT32_SERIAL_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      borrow <= 1'b0;
      ovf <= 1'b0;
    end else if (last) begin
      borrow <= ~c[BITS_PER_CYCLE];
      ovf <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
    end
  end
`endif
endmodule

// File: tb/tb_sub_int32_serial.sv
// tb_sub_int32_serial: directed and random checks of the serial subtractor against an arithmetic model
module tb_sub_int32_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] a = '0, b = '0, diff;
  logic in_valid4 = 1'b0, out_ready4 = 1'b1, in_ready4, out_valid4;
  logic [31:0] a4 = '0, b4 = '0, diff4;
`ifdef SUB_INT32_SERIAL_FLAGS_EN
  logic borrow, ovf, borrow4, ovf4;
`endif
  sub_int32_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff)
`ifdef SUB_INT32_SERIAL_FLAGS_EN
    , .borrow(borrow), .ovf(ovf)
`endif
  );
  sub_int32_serial #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .diff(diff4)
`ifdef SUB_INT32_SERIAL_FLAGS_EN
    , .borrow(borrow4), .ovf(ovf4)
`endif
  );
  int errors = 0, checks = 0, cyc = 0, acc_edge = 0;
  bit prev_ov = 1'b0;
  logic [33:0] exp_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // {borrow, ovf, diff} from plain unsigned/signed arithmetic
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return {x < y, (x[31] != y[31]) && (d[31] != x[31]), d};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_ov = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_diff", diff, 0);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
      chk("rst_flags", {30'd0, borrow, ovf}, 0);
`endif
    end else begin
      if (out_valid) begin
        chk("done_in_ready", 32'(in_ready), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
        end else begin
          chk("diff", diff, exp_q[0][31:0]);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
          chk("borrow", 32'(borrow), 32'(exp_q[0][33]));
          chk("ovf", 32'(ovf), 32'(exp_q[0][32]));
`endif
          if (!prev_ov) chk("latency", 32'(cyc - acc_edge), 32);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        acc_edge = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept within 200 cycles");
    end
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask
  task automatic consume();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] x, y;
    logic [33:0] e;
    int n, lat;
    bit acc;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'd10, 32'd3);
    wait_valid();
    chk("t1_diff", diff, 32'd7);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
    chk("t1_flags", {30'd0, borrow, ovf}, 0);
`endif
    consume();
    send(32'd0, 32'd1);
    wait_valid();
    chk("t2_diff", diff, 32'hFFFF_FFFF);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
    chk("t2_flags", {30'd0, borrow, ovf}, 32'd2);
`endif
    consume();
    send(32'h8000_0000, 32'd1);
    wait_valid();
    chk("t3_diff", diff, 32'h7FFF_FFFF);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
    chk("t3_flags", {30'd0, borrow, ovf}, 32'd1);
`endif
    consume();
    out_ready = 1'b0;
    send(32'd20, 32'd7);
    wait_valid();
    fork
      send(32'd5, 32'd5);
      begin
        repeat (10) begin
          chk("bp_in_ready", 32'(in_ready), 0);
          chk("bp_out_valid", 32'(out_valid), 1);
          chk("bp_diff", diff, 32'd13);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_valid();
    chk("bp2_diff", diff, 32'd0);
    consume();
    send(32'd1234, 32'd1);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_diff", diff, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(32'd100, 32'd58);
    wait_valid();
    chk("t5_diff", diff, 32'd42);
    consume();
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? 32'd0 : (i == 1) ? 32'h8000_0000 : $urandom;
      y = (i < 2) ? 32'd1 : $urandom;
      e = model(x, y);
      in_valid4 = 1'b1;
      a4 = x;
      b4 = y;
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready4;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 50);
      in_valid4 = 1'b0;
      a4 = $urandom;
      b4 = $urandom;
      lat = 0;
      @(negedge clk);
      while (!out_valid4 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk("bpc4_latency", 32'(lat), 32'd8);
      chk("bpc4_diff", diff4, e[31:0]);
`ifdef SUB_INT32_SERIAL_FLAGS_EN
      chk("bpc4_flags", {30'd0, borrow4, ovf4}, {30'd0, e[33:32]});
`endif
      consume();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
